// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, byte width and R/W bit encoding.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_MACK,
    IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with edge history; flags SCL edges and START/STOP.
// Events are combinational from the history flop, so they land 3 CLK after a pin change.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;
  logic       scl_s;
  logic       sda_s;

  // Reset to the idle-bus level so release from reset never looks like STOP.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  assign start_o    = scl_s & scl_hist_q & ~sda_s & sda_hist_q;
  assign stop_o     = scl_s & scl_hist_q & sda_s & ~sda_hist_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: address match, write-byte reception, read-byte
// transmission and ACK handling; SDA is driven only through an open-drain pull-low.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         WIDTH      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_pull_low,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_load,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rw,
  output logic             busy,
  output logic             start_det,
  output logic             stop_det
);

  localparam logic [2:0] LAST_BIT = 3'(I2C_BYTE_W - 1);

  logic sda_s, scl_rise, scl_fall, start_ev, stop_ev;

  i2c_bus_sync u_sync (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_ev),
    .stop_o     (stop_ev)
  );

  i2c_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rw_q, rw_d;
  logic             busy_q, busy_d;
  logic             pull_q, pull_d;
  logic             ack_ok_q, ack_ok_d;
  logic             pend_q, pend_d;
  logic             rx_valid_q, rx_valid_d;
  logic             tx_load_q, tx_load_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic [WIDTH-1:0] shift_in;

  assign shift_in = {shift_q[WIDTH-2:0], sda_s};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      pull_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      pend_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      pull_q     <= pull_d;
      ack_ok_q   <= ack_ok_d;
      pend_q     <= pend_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    pull_d     = pull_q;
    ack_ok_d   = ack_ok_q;
    pend_d     = pend_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;

    if (start_ev) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      pull_d    = 1'b0;
      busy_d    = 1'b0;
      pend_d    = 1'b0;
      start_d   = 1'b1;
    end else if (stop_ev) begin
      state_d = IDLE;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
      pend_d  = 1'b0;
      stop_d  = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              if (shift_in[WIDTH-1 -: 7] == SLAVE_ADDR) begin
                rw_d   = shift_in[0];
                pend_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end else if (scl_fall && pend_q) begin
            pend_d  = 1'b0;
            pull_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = ADDR_ACK;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            case (rw_q)
              RW_READ: begin
                shift_d   = tx_data;
                tx_load_d = 1'b1;
                pull_d    = ~tx_data[WIDTH-1];
                bit_cnt_d = '0;
                state_d   = TX_BYTE;
              end
              RW_WRITE: begin
                pull_d  = 1'b0;
                state_d = RX_BYTE;
              end
            endcase
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              ack_ok_d   = rx_ready;
              pend_d     = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d  = 1'b0;
            pull_d  = ack_ok_q;
            state_d = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            pull_d = 1'b0;
            if (ack_ok_q) begin
              state_d = RX_BYTE;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        TX_BYTE: begin
          // Each falling edge ends one bit; the last one hands SDA back to the master.
          if (scl_fall) begin
            if (bit_cnt_q == LAST_BIT) begin
              pull_d    = 1'b0;
              bit_cnt_d = '0;
              state_d   = TX_MACK;
            end else begin
              shift_d   = {shift_q[WIDTH-2:0], 1'b0};
              pull_d    = ~shift_q[WIDTH-2];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        TX_MACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end else begin
              pend_d = 1'b1;
            end
          end else if (scl_fall && pend_q) begin
            pend_d    = 1'b0;
            shift_d   = tx_data;
            tx_load_d = 1'b1;
            pull_d    = ~tx_data[WIDTH-1];
            bit_cnt_d = '0;
            state_d   = TX_BYTE;
          end
        end
        default: begin
          pull_d = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  // The state gate keeps SDA released in IDLE/ADDR/IGNORE regardless of pull_q.
  always_comb begin
    sda_pull_low = pull_q && (state_q inside {ADDR_ACK, RX_ACK, TX_BYTE});
    tx_load      = tx_load_q;
    rx_data      = rx_data_q;
    rx_valid     = rx_valid_q;
    rw           = rw_q;
    busy         = busy_q;
    start_det    = start_q;
    stop_det     = stop_q;
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: a bit-banged I2C master plus a transaction-level model
// of what the slave should acknowledge, transmit, receive and flag.
module tb_i2c_slave_ctrl;

  localparam logic [6:0] ADDR7 = 7'h50;

  logic       CLK = 1'b0;
  logic       RST;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_pull_low;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, rx_ready, rx_valid, rw, busy, start_det, stop_det;

  assign sda_line = sda_m & ~sda_pull_low;

  always #5 CLK = ~CLK;

  i2c_slave_ctrl #(.SLAVE_ADDR(ADDR7), .WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_pull_low (sda_pull_low),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rw           (rw),
    .busy         (busy),
    .start_det    (start_det),
    .stop_det     (stop_det)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the slave as seen from the bus.
  typedef enum {M_IDLE, M_ADDR, M_WDATA, M_RDATA, M_DEAD} mph_e;
  mph_e       mph = M_IDLE;
  logic       exp_busy = 1'b0, exp_rw = 1'b0, addr_ack_ph = 1'b0;
  logic       matched = 1'b0, exp_ack = 1'b0, ack_cap = 1'b0, load_pend = 1'b0;
  logic [7:0] exp_tx = 8'h00;
  logic [7:0] rxq[$];
  logic [7:0] tx_seq[$];
  int         n_rxv = 0, n_txl = 0, n_start = 0, n_stop = 0;
  int         e_rxv = 0, e_txl = 0, e_start = 0, e_stop = 0;
  logic       stable = 1'b0;

  always @(negedge CLK) begin
    if (rx_valid) begin
      n_rxv++;
      if (rxq.size() == 0) check("rx_valid_spurious", rx_valid, 0);
      else check("rx_data", rx_data, rxq.pop_front());
    end
    if (tx_load) n_txl++;
    if (start_det) n_start++;
    if (stop_det) n_stop++;
    if (stable) begin
      check("busy", busy, exp_busy);
      check("rw", rw, exp_rw);
      if (!(mph == M_WDATA || mph == M_RDATA || addr_ack_ph))
        check("sda_released", sda_pull_low, 0);
    end
  end

  function automatic logic [7:0] next_tx();
    if (tx_seq.size() != 0) return tx_seq.pop_front();
    return 8'($urandom);
  endfunction

  task automatic set_pins(input logic scl, input logic sda);
    stable = 1'b0;
    scl_m  = scl;
    sda_m  = sda;
  endtask

  task automatic settle();
    repeat (6) @(posedge CLK);
    #1 stable = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
  endtask

  task automatic do_load();
    exp_tx    = tx_data;
    e_txl++;
    load_pend = 1'b1;
  endtask

  task automatic refresh_tx();
    if (load_pend) begin
      load_pend = 1'b0;
      tx_data   = next_tx();
    end
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      set_pins(0, 1); settle();
      set_pins(1, 1); settle();
    end
    set_pins(1, 0);
    mph = M_ADDR; exp_busy = 1'b0; addr_ack_ph = 1'b0; matched = 1'b0; e_start++;
    settle();
    set_pins(0, 0); settle();
  endtask

  task automatic bus_stop();
    set_pins(0, 0); settle();
    set_pins(1, 0); settle();
    set_pins(1, 1);
    mph = M_IDLE; exp_busy = 1'b0; addr_ack_ph = 1'b0; e_stop++;
    settle();
  endtask

  task automatic mwrite(input logic [7:0] b);
    string nm;
    nm = (mph == M_ADDR) ? "addr_ack" : "data_ack";
    for (int i = 7; i >= 1; i--) begin
      set_pins(0, b[i]); settle();
      set_pins(1, b[i]); settle();
      set_pins(0, b[i]); settle();
    end
    set_pins(0, b[0]); settle();
    set_pins(1, b[0]);
    if (mph == M_ADDR) begin
      if (b[7:1] == ADDR7) begin matched = 1'b1; exp_rw = b[0]; end
      else mph = M_DEAD;
    end else if (mph == M_WDATA) begin
      rxq.push_back(b); e_rxv++; ack_cap = rx_ready;
    end
    settle();
    set_pins(0, b[0]);
    exp_ack = 1'b0;
    if (mph == M_ADDR && matched) begin
      exp_busy = 1'b1; exp_ack = 1'b1; addr_ack_ph = 1'b1;
    end else if (mph == M_WDATA) begin
      exp_ack = ack_cap;
    end
    settle();
    set_pins(0, 1); settle();
    set_pins(1, 1); settle();
    check(nm, sda_line, !exp_ack);
    set_pins(0, 1);
    if (mph == M_ADDR && matched) begin
      addr_ack_ph = 1'b0;
      if (exp_rw) begin mph = M_RDATA; do_load(); end
      else mph = M_WDATA;
    end else if (mph == M_WDATA && !ack_cap) begin
      mph = M_DEAD; exp_busy = 1'b0;
    end
    settle();
    refresh_tx();
  endtask

  task automatic mread(input logic mack, output logic [7:0] got);
    logic a;
    a = !mack;
    for (int i = 7; i >= 0; i--) begin
      set_pins(0, 1); settle();
      set_pins(1, 1); settle();
      got[i] = sda_line;
      set_pins(0, 1); settle();
    end
    check("rd_byte", got, (mph == M_RDATA) ? exp_tx : 8'hFF);
    set_pins(0, a); settle();
    set_pins(1, a);
    if (mph == M_RDATA && !mack) begin mph = M_DEAD; exp_busy = 1'b0; end
    settle();
    set_pins(0, a);
    if (mph == M_RDATA && mack) do_load();
    settle();
    refresh_tx();
  endtask

  initial begin
    logic [7:0] g;
    int         s0, r0, t0;
    logic [6:0] a7;
    logic       r;
    int         nb;

    RST = 1'b0; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00; rx_ready = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("rst_sda_pull_low", sda_pull_low, 0);
    check("rst_busy", busy, 0);
    check("rst_rw", rw, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_pulses", {rx_valid, tx_load, start_det, stop_det}, 4'b0000);
    @(posedge CLK); #1 RST = 1'b1;
    settle();

    // Write 0xA5 to address 0x50
    bus_start();
    mwrite(8'hA0);
    mwrite(8'hA5);
    check("wr_rx_data", rx_data, 8'hA5);
    check("wr_rw", rw, 0);
    check("wr_busy", busy, 1);
    check("wr_rxv_count", n_rxv, 1);
    bus_stop();
    check("wr_busy_after_stop", busy, 0);
    check("wr_stop_count", n_stop, 1);

    // Read 0x3C (ACK) then 0xC3 (NACK)
    tx_data = 8'h3C; tx_seq.push_back(8'hC3);
    t0 = n_txl;
    bus_start();
    mwrite(8'hA1);
    mread(1'b1, g); check("rd_first", g, 8'h3C);
    mread(1'b0, g); check("rd_second", g, 8'hC3);
    check("rd_loads", n_txl - t0, 2);
    check("rd_busy_after_nack", busy, 0);
    check("rd_sda_after_nack", sda_pull_low, 0);
    bus_stop();

    // Wrong address 0x51
    r0 = n_rxv; s0 = n_stop;
    bus_start();
    mwrite(8'hA2);
    mwrite(8'h11);
    check("badaddr_busy", busy, 0);
    bus_stop();
    check("badaddr_no_rxv", n_rxv - r0, 0);
    check("badaddr_stop", n_stop - s0, 1);

    // Data side not ready: NACK, byte still reported, later bytes ignored
    r0 = n_rxv;
    bus_start();
    mwrite(8'hA0);
    rx_ready = 1'b0;
    mwrite(8'h5A);
    rx_ready = 1'b1;
    mwrite(8'h77);
    check("nack_rx_data", rx_data, 8'h5A);
    check("nack_rxv", n_rxv - r0, 1);
    bus_stop();

    // Repeated START switching from write to read
    s0 = n_start;
    bus_start();
    mwrite(8'hA0);
    bus_start();
    mwrite(8'hA1);
    check("rs_rw", rw, 1);
    mread(1'b0, g);
    check("rs_starts", n_start - s0, 2);
    bus_stop();

    // Reset while the slave drives a 0 bit
    tx_data = 8'h3C;
    bus_start();
    mwrite(8'hA1);
    check("pre_rst_pull", sda_pull_low, 1);
    @(posedge CLK); #1;
    stable = 1'b0; RST = 1'b0;
    mph = M_IDLE; exp_busy = 1'b0; exp_rw = 1'b0; addr_ack_ph = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("rst_mid_pull", sda_pull_low, 0);
    check("rst_mid_busy", busy, 0);
    repeat (3) @(posedge CLK); #1 RST = 1'b1;
    mwrite(8'hA0);
    mwrite(8'h42);
    bus_stop();

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      bus_start();
      a7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR7;
      r  = 1'($urandom_range(0, 1));
      mwrite({a7, r});
      if (!r) begin
        nb = $urandom_range(0, 3);
        for (int j = 0; j < nb; j++) begin
          rx_ready = ($urandom_range(0, 3) != 0);
          mwrite(8'($urandom));
        end
        rx_ready = 1'b1;
      end else if (mph == M_RDATA) begin
        nb = $urandom_range(1, 3);
        for (int j = 0; j < nb; j++) mread(j < nb - 1, g);
      end
      if ($urandom_range(0, 3) != 0) bus_stop();
    end
    bus_stop();

    check("total_rx_valid", n_rxv, e_rxv);
    check("total_tx_load", n_txl, e_txl);
    check("total_start", n_start, e_start);
    check("total_stop", n_stop, e_stop);
    check("rxq_drained", rxq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl.md
Name: i2c_slave_ctrl

Overview:
Protocol controller for the I2C slave. Oversamples SCL/SDA on the system clock, detects START/STOP, and shifts and matches the 7-bit address. It then sequences write-data reception and read-data transmission, including address, data and master ACK/NACK phases. It drives SDA only through an open-drain pull-low enable and exchanges bytes with the register/data side through simple strobes.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this slave responds to
WIDTH, 8, data byte width; fixed at 8 for I2C, used for bus sizing only

Ports:
CLK  input  1  system clock, at least 8x the SCL rate
RST  input  1  synchronous, active-low reset
scl_in  input  1  raw SCL pin value (asynchronous)
sda_in  input  1  raw SDA pin value (asynchronous)
sda_pull_low  output  1  1 = drive SDA low; 0 = release
tx_data  input  WIDTH  next byte to transmit on a read
tx_load  output  1  1-CLK pulse when tx_data is latched into the shifter
rx_ready  input  1  data side can accept a byte; sampled to choose ACK or NACK
rx_data  output  WIDTH  last received write byte
rx_valid  output  1  1-CLK pulse when rx_data updates
rw  output  1  R/W bit of the current transfer (1 = read)
busy  output  1  slave addressed; high from address ACK until STOP or START
start_det  output  1  1-CLK pulse on START or repeated START
stop_det  output  1  1-CLK pulse on STOP

Behaviour:
- Reset (RST=0 at a CLK edge): state IDLE, bit counter 0, shifters 0, all outputs 0, sda_pull_low=0.
- Input conditioning: 2-flop synchronizer on each of scl_in and sda_in, plus one history flop for edge detection. Event latency is 3 CLK from the pin change.
- Bus events, derived from synchronized signals:
  - scl_rise / scl_fall: SCL transitions.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Priority: START/STOP override any bit event in the same CLK.
  - START from any state → ADDR, counter cleared, sda_pull_low released, start_det pulsed. This covers repeated START.
  - STOP from any state → IDLE, SDA released, busy=0, stop_det pulsed.
- Sampling rules: bits are sampled on scl_rise, MSB first. SDA output changes only on scl_fall.
- States:
  - IDLE: ignores bits; waits for START.
  - ADDR: shifts 8 bits (7 address bits + R/W).
    - On the 8th scl_rise: on match, latch rw and set pending-ACK; on mismatch → IGNORE.
    - On the next scl_fall: assert sda_pull_low, set busy, → ADDR_ACK.
  - ADDR_ACK: at the scl_fall ending the ACK bit:
    - rw=0: release SDA, → RX_BYTE.
    - rw=1: latch tx_data, pulse tx_load, drive bit7 (sda_pull_low = ~bit), → TX_BYTE.
  - RX_BYTE: shifts 8 bits.
    - On the 8th scl_rise: rx_data <= shifter; pulse rx_valid; capture ack_ok = rx_ready.
    - On the next scl_fall: sda_pull_low = ack_ok, → RX_ACK.
  - RX_ACK: at the scl_fall ending the ACK bit, release SDA.
    - ack_ok=1 → RX_BYTE.
    - ack_ok=0 (NACK) → IGNORE.
  - TX_BYTE: each scl_fall after a bit shifts out the next bit.
    - After the 8th bit's scl_fall, release SDA and → TX_MACK.
  - TX_MACK: on scl_rise, sample SDA.
    - SDA=0 (ACK): at the next scl_fall, latch tx_data, pulse tx_load, drive bit7, → TX_BYTE.
    - SDA=1 (NACK): → IGNORE with SDA released.
  - IGNORE: SDA released, busy=0; waits for START or STOP.
- Bit counter: 3 bits, wraps 7→0 at byte end; cleared on START.
- RST low mid-transfer: immediate return to the reset values above. SDA is released within the same CLK edge.
- SDA is never driven in IDLE, ADDR or IGNORE. SDA never changes while synchronized SCL is high.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_MACK, IGNORE);
  - I2C_BYTE_W=8;
  - the R/W encoding constants.
- One sub-module, i2c_bus_sync: synchronizers plus START/STOP/scl_rise/scl_fall detection. It is reusable by the master side.

Test Plan:
- Write 0xA0 (addr 0x50, W) then data 0xA5, rx_ready=1 → sda_pull_low on both 9th bits, rx_data=0xA5, a single rx_valid pulse, rw=0, busy=1 until STOP, then stop_det.
- Read 0xA1 with tx_data=0x3C, master ACKs, then tx_data=0xC3 with master NACK:
  - SDA serializes 0011_1100 then 1100_0011.
  - Two tx_load pulses.
  - After the NACK: SDA released, state IGNORE, busy=0.
- Address 0x51 → no ACK (SDA high on the 9th bit), no rx_valid, busy=0; a following STOP pulses stop_det.
- Write with rx_ready=0 at the 8th data bit → NACK on the 9th bit, rx_valid still pulses with the byte, subsequent bytes ignored.
- Repeated START after an address ACK, then address 0xA1 → start_det pulses twice, rw switches to 1, read proceeds.
- RST=0 asserted while driving a 0 bit in TX_BYTE → sda_pull_low=0 on the next CLK, busy=0, later traffic ignored until a new START.
